// File: rtl/ov7670_config_ctrl.sv
// ov7670_config_ctrl: walks the OV7670 config ROM and issues each entry as an SCCB write
module ov7670_config_ctrl #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int RESET_DELAY_MS = 10,
  parameter int DELAY_CYCLES   = CLK_FREQ_HZ / 1000 * RESET_DELAY_MS,
  parameter int GAP_CYCLES     = 256,
  parameter int MAX_RETRY      = 3,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              busy,
  output logic              config_done,
  output logic              config_err,
  output logic [ADDR_W-1:0] err_addr
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [3:0] {IDLE, ROM_WAIT, DECODE, SEND, WAIT_ACK, DELAY, GAP, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [31:0]   cnt;
  logic [RW-1:0] retry;
  logic          cnt_zero, last, advance, idle_like;
  assign cnt_zero  = cnt == '0;
  assign last      = &rom_addr;
  assign idle_like = state == IDLE || state == DONE || state == ERROR;
  // next state, the SCCB request strobe and the ROM-advance decision
  always_comb begin
    state_n    = state;
    sccb_start = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE, DONE, ERROR: state_n = start ? ROM_WAIT : state;
      ROM_WAIT: state_n = cnt_zero ? DECODE : ROM_WAIT;
      DECODE:   state_n = rom_data == 16'hFFFF ? DONE : rom_data == 16'hFFF0 ? DELAY : SEND;
      SEND: begin
        sccb_start = !sccb_busy;
        state_n    = sccb_busy ? SEND : WAIT_ACK;
      end
      WAIT_ACK: if (sccb_done) state_n = sccb_nack && retry == RW'(MAX_RETRY) ? ERROR : GAP;
      GAP: if (cnt_zero) begin
        advance = retry == '0;
        state_n = retry != '0 ? SEND : last ? DONE : ROM_WAIT;
      end
      DELAY: if (cnt_zero) begin
        advance = 1'b1;
        state_n = last ? DONE : ROM_WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // counters, ROM address, latched write data and status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr    <= '0;
      sccb_reg    <= '0;
      sccb_val    <= '0;
      busy        <= 1'b0;
      config_done <= 1'b0;
      config_err  <= 1'b0;
      err_addr    <= '0;
      retry       <= '0;
      cnt         <= '0;
    end else begin
      if (state_n == ROM_WAIT && state != ROM_WAIT) cnt <= 32'd1;
      else if (state == DECODE && state_n == DELAY) cnt <= 32'(DELAY_CYCLES - 1);
      else if (state == WAIT_ACK && state_n == GAP) cnt <= 32'(GAP_CYCLES - 1);
      else if (!cnt_zero) cnt <= cnt - 1'b1;
      if (idle_like && start) begin
        rom_addr    <= '0;
        retry       <= '0;
        config_done <= 1'b0;
        config_err  <= 1'b0;
        busy        <= 1'b1;
      end
      if (advance && !last) rom_addr <= rom_addr + 1'b1;
      if (state == DECODE && state_n == SEND) {sccb_reg, sccb_val} <= rom_data;
      if (state == WAIT_ACK && sccb_done) retry <= sccb_nack ? retry + 1'b1 : '0;
      if (state_n == DONE && state != DONE) begin
        config_done <= 1'b1;
        busy        <= 1'b0;
      end
      if (state_n == ERROR && state != ERROR) begin
        config_err <= 1'b1;
        err_addr   <= rom_addr;
        busy       <= 1'b0;
      end
    end
endmodule
